// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: addresses, operation and
// state encodings, trap cause codes and the read-modify-write helper.
package csr_pkg;

  localparam int DATA_SIZE = 32;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_t;

  typedef enum logic {
    RUN   = 1'b0,
    SLEEP = 1'b1
  } csr_state_t;

  localparam logic [31:0] CAUSE_EXT_IRQ   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER_IRQ = 32'h8000_0007;
  localparam logic [31:0] MSTATUS_RST     = 32'h0000_1800;

  function automatic logic [31:0] csr_wval(input csr_op_t op, input logic [31:0] old_val,
                                           input logic [31:0] wdata);
    case (op)
      OP_RW:   return wdata;
      OP_RS:   return old_val | wdata;
      OP_RC:   return old_val & ~wdata;
      default: return old_val;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently writable halves.
// Any write in a cycle suppresses that cycle's increment.
import csr_pkg::*;

module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  always_ff @(posedge clk) begin
    if (rst)        count <= '0;
    else if (wr_lo) count[31:0] <= wdata;
    else if (wr_hi) count[63:32] <= wdata;
    else if (inc)   count <= count + 64'd1;
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file with interrupt entry, MRET, WFI sleep and counters.
// trap_taken / mret_taken are single-cycle redirect strobes, valid in the cycle they are high.
import csr_pkg::*;

module csr_unit #(
  parameter logic [31:0] MTVEC_RST = 32'h0,
  parameter logic [31:0] HART_ID   = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 csr_en_EXE,
  input  logic [1:0]           csr_op_EXE,
  input  logic [11:0]          csr_addr_EXE,
  input  logic                 csr_src_zero_EXE,
  input  logic [DATA_SIZE-1:0] csr_write_tmp,
  input  logic [DATA_SIZE-1:0] PC_EXE,
  input  logic                 mret_EXE,
  input  logic                 wfi_EXE,
  input  logic                 stall,
  input  logic                 instr_retire,
  input  logic                 ext_irq,
  input  logic                 timer_irq,
  output logic [DATA_SIZE-1:0] csr_rdata,
  output logic                 trap_taken,
  output logic                 mret_taken,
  output logic [DATA_SIZE-1:0] trap_target,
  output logic                 csr_stall,
  output csr_state_t           csr_state
);

  csr_state_t  state, next_state;
  csr_op_t     op;
  logic        mstatus_mie, mstatus_mpie, mie_meie, mie_mtie;
  logic [31:2] mtvec_q, mepc_q, wake_pc;
  logic [31:0] mscratch, mcause;
  logic [63:0] mcycle, minstret;
  logic [31:0] mip_val, mie_val, mstatus_val, pend, rd_val, wval, irq_cause;
  logic        irq_pend, take_irq, csr_wr;
  logic        unused_bits;

  assign op          = csr_op_t'(csr_op_EXE);
  assign mip_val     = {20'b0, ext_irq, 3'b0, timer_irq, 7'b0};
  assign mie_val     = {20'b0, mie_meie, 3'b0, mie_mtie, 7'b0};
  assign mstatus_val = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
  assign pend        = mie_val & mip_val;
  assign irq_pend    = |pend;
  assign irq_cause   = pend[11] ? CAUSE_EXT_IRQ : CAUSE_TIMER_IRQ;
  assign unused_bits = ^PC_EXE[1:0];
  assign csr_state   = state;

  // Sleep wake-up with MIE set is taken regardless of the pipeline stall.
  assign take_irq = mstatus_mie & irq_pend & ((state == SLEEP) | !stall);

  assign csr_wr = csr_en_EXE & (op != OP_NONE) & !stall & !take_irq & (state == RUN)
                & !(csr_src_zero_EXE & (op == OP_RS || op == OP_RC));
  assign wval   = csr_wval(op, rd_val, csr_write_tmp);

  always_comb begin
    rd_val = '0;
    case (csr_addr_EXE)
      CSR_MSTATUS:   rd_val = mstatus_val;
      CSR_MIE:       rd_val = mie_val;
      CSR_MIP:       rd_val = mip_val;
      CSR_MTVEC:     rd_val = {mtvec_q, 2'b00};
      CSR_MSCRATCH:  rd_val = mscratch;
      CSR_MEPC:      rd_val = {mepc_q, 2'b00};
      CSR_MCAUSE:    rd_val = mcause;
      CSR_MCYCLE:    rd_val = mcycle[31:0];
      CSR_MCYCLEH:   rd_val = mcycle[63:32];
      CSR_MINSTRET:  rd_val = minstret[31:0];
      CSR_MINSTRETH: rd_val = minstret[63:32];
      CSR_MHARTID:   rd_val = HART_ID;
      default:       rd_val = '0;
    endcase
  end

  assign csr_rdata = csr_en_EXE ? rd_val : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= next_state;
  end

  // A WFI that sees an interrupt already pending completes as a NOP.
  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (wfi_EXE && !stall && !take_irq && !irq_pend) next_state = SLEEP;
      SLEEP:   if (irq_pend) next_state = RUN;
      default: next_state = RUN;
    endcase
  end

  always_comb begin
    csr_stall   = (state == SLEEP);
    trap_taken  = take_irq;
    mret_taken  = (state == RUN) & mret_EXE & !stall & !take_irq;
    trap_target = '0;
    if (take_irq)        trap_target = {mtvec_q, 2'b00};
    else if (mret_taken) trap_target = {mepc_q, 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie  <= MSTATUS_RST[3];
      mstatus_mpie <= MSTATUS_RST[7];
      mie_meie     <= 1'b0;
      mie_mtie     <= 1'b0;
      mtvec_q      <= MTVEC_RST[31:2];
      mscratch     <= '0;
      mepc_q       <= '0;
      mcause       <= '0;
      wake_pc      <= '0;
    end else begin
      if (take_irq) begin
        mepc_q       <= (state == SLEEP) ? wake_pc : PC_EXE[31:2];
        mcause       <= irq_cause;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (mret_taken) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (csr_wr) begin
        case (csr_addr_EXE)
          CSR_MSTATUS: begin
            mstatus_mie  <= wval[3];
            mstatus_mpie <= wval[7];
          end
          CSR_MIE: begin
            mie_meie <= wval[11];
            mie_mtie <= wval[7];
          end
          CSR_MTVEC:    mtvec_q  <= wval[31:2];
          CSR_MSCRATCH: mscratch <= wval;
          CSR_MEPC:     mepc_q   <= wval[31:2];
          CSR_MCAUSE:   mcause   <= wval;
          default: ;
        endcase
      end
      if (state == RUN && next_state == SLEEP) wake_pc <= PC_EXE[31:2] + 30'd1;
    end
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (csr_wr && csr_addr_EXE == CSR_MCYCLE),
    .wr_hi (csr_wr && csr_addr_EXE == CSR_MCYCLEH),
    .wdata (wval),
    .count (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (instr_retire && state == RUN),
    .wr_lo (csr_wr && csr_addr_EXE == CSR_MINSTRET),
    .wr_hi (csr_wr && csr_addr_EXE == CSR_MINSTRETH),
    .wdata (wval),
    .count (minstret)
  );

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: drivers push expected output vectors, a negedge
// monitor pops and compares them against {sleep, trap, mret, stall, target, rdata}.
module tb_csr_unit;
  import csr_pkg::*;

  localparam logic [31:0] HART = 32'h0000_0003;
  localparam int W = 68;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_en_EXE, csr_src_zero_EXE, mret_EXE, wfi_EXE, stall;
  logic        instr_retire, ext_irq, timer_irq;
  logic [1:0]  csr_op_EXE;
  logic [11:0] csr_addr_EXE;
  logic [31:0] csr_write_tmp, PC_EXE;
  logic [31:0] csr_rdata, trap_target;
  logic        trap_taken, mret_taken, csr_stall;
  csr_state_t  csr_state;

  always #5 clk = ~clk;

  csr_unit #(.MTVEC_RST(32'h0), .HART_ID(HART)) dut (
    .clk              (clk),
    .rst              (rst),
    .csr_en_EXE       (csr_en_EXE),
    .csr_op_EXE       (csr_op_EXE),
    .csr_addr_EXE     (csr_addr_EXE),
    .csr_src_zero_EXE (csr_src_zero_EXE),
    .csr_write_tmp    (csr_write_tmp),
    .PC_EXE           (PC_EXE),
    .mret_EXE         (mret_EXE),
    .wfi_EXE          (wfi_EXE),
    .stall            (stall),
    .instr_retire     (instr_retire),
    .ext_irq          (ext_irq),
    .timer_irq        (timer_irq),
    .csr_rdata        (csr_rdata),
    .trap_taken       (trap_taken),
    .mret_taken       (mret_taken),
    .trap_target      (trap_target),
    .csr_stall        (csr_stall),
    .csr_state        (csr_state)
  );

  // Scoreboard
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           passed = 0;
  logic         mon_en = 1'b0;
  logic [W-1:0] obs, exp_v;
  string        nm;

  always @(negedge clk) begin
    if (mon_en) begin
      obs = {csr_state == SLEEP, trap_taken, mret_taken, csr_stall, trap_target, csr_rdata};
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL monitor: output %h with no expected entry", obs);
      end else begin
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        if (obs === exp_v) passed++;
        else $display("FAIL %s: got sleep/trap/mret/stall=%b target=%h rdata=%h, expected %b target=%h rdata=%h",
                      nm, obs[67:64], obs[63:32], obs[31:0], exp_v[67:64], exp_v[63:32], exp_v[31:0]);
      end
    end
  end

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
    csr_en_EXE = 1'b0; csr_op_EXE = 2'b00; csr_addr_EXE = '0; csr_src_zero_EXE = 1'b0;
    csr_write_tmp = '0; mret_EXE = 1'b0; wfi_EXE = 1'b0; mon_en = 1'b0;
  endtask

  task automatic expect_out(input string n, input logic sl, input logic tr, input logic mr,
                            input logic st, input logic [31:0] tgt, input logic [31:0] rd);
    exp_q.push_back({sl, tr, mr, st, tgt, rd});
    name_q.push_back(n);
    mon_en = 1'b1;
  endtask

  task automatic csr_cmd(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                         input logic z);
    csr_en_EXE = 1'b1; csr_op_EXE = op; csr_addr_EXE = a; csr_write_tmp = wd; csr_src_zero_EXE = z;
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
    csr_cmd(op, a, wd, 1'b0);
    tick();
  endtask

  task automatic op_chk(input string n, input logic [1:0] op, input logic [11:0] a,
                        input logic [31:0] wd, input logic [31:0] old_val);
    csr_cmd(op, a, wd, 1'b0);
    expect_out(n, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, old_val);
    tick();
  endtask

  task automatic rd_chk(input string n, input logic [11:0] a, input logic [31:0] v);
    csr_cmd(2'b10, a, 32'h0, 1'b1);
    expect_out(n, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, v);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; stall = 1'b0; instr_retire = 1'b0; ext_irq = 1'b0; timer_irq = 1'b0;
    PC_EXE = '0; csr_en_EXE = 1'b0; csr_op_EXE = 2'b00; csr_addr_EXE = '0;
    csr_src_zero_EXE = 1'b0; csr_write_tmp = '0; mret_EXE = 1'b0; wfi_EXE = 1'b0;
    @(posedge clk); #1;
    expect_out("reset_outputs", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    rd_chk("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
    rd_chk("rst_mie", CSR_MIE, 32'h0);
    rd_chk("rst_mtvec", CSR_MTVEC, 32'h0);
    rd_chk("rst_mepc", CSR_MEPC, 32'h0);
    rd_chk("rst_mcause", CSR_MCAUSE, 32'h0);
    rd_chk("mhartid", CSR_MHARTID, HART);

    // Read-modify-write operations on mscratch
    op_chk("rw_mscratch", 2'b01, CSR_MSCRATCH, 32'hDEAD_BEEF, 32'h0);
    op_chk("rs_mscratch", 2'b10, CSR_MSCRATCH, 32'h0000_00F0, 32'hDEAD_BEEF);
    rd_chk("rs_result", CSR_MSCRATCH, 32'hDEAD_BEFF);
    op_chk("rc_mscratch", 2'b11, CSR_MSCRATCH, 32'h0000_00FF, 32'hDEAD_BEFF);
    rd_chk("rc_result", CSR_MSCRATCH, 32'hDEAD_BE00);
    op_chk("unimpl_write", 2'b01, 12'h7C0, 32'h1234_5678, 32'h0);
    rd_chk("unimpl_read", 12'h7C0, 32'h0);
    op_chk("hartid_write", 2'b01, CSR_MHARTID, 32'hFFFF_FFFF, HART);
    rd_chk("hartid_readonly", CSR_MHARTID, HART);
    stall = 1'b1;
    op_chk("stalled_write", 2'b01, CSR_MSCRATCH, 32'h1111_1111, 32'hDEAD_BE00);
    stall = 1'b0;
    rd_chk("stalled_dropped", CSR_MSCRATCH, 32'hDEAD_BE00);

    // Counters
    wr(2'b01, CSR_MCYCLE, 32'hFFFF_FFFF);
    wr(2'b01, CSR_MCYCLEH, 32'h0);
    tick();
    rd_chk("mcycleh_carry", CSR_MCYCLEH, 32'h1);
    rd_chk("mcycle_after_carry", CSR_MCYCLE, 32'h1);
    wr(2'b01, CSR_MCYCLE, 32'h0000_0100);
    rd_chk("mcycle_write_wins", CSR_MCYCLE, 32'h0000_0100);
    rd_chk("mcycle_counts", CSR_MCYCLE, 32'h0000_0101);
    instr_retire = 1'b1;
    wr(2'b01, CSR_MINSTRET, 32'h5);
    instr_retire = 1'b0;
    rd_chk("minstret_write_wins", CSR_MINSTRET, 32'h5);
    instr_retire = 1'b1;
    repeat (3) tick();
    instr_retire = 1'b0;
    rd_chk("minstret_retire", CSR_MINSTRET, 32'h8);
    wr(2'b01, CSR_MINSTRETH, 32'hFFFF_FFFF);
    wr(2'b01, CSR_MINSTRET, 32'hFFFF_FFFF);
    instr_retire = 1'b1;
    tick();
    instr_retire = 1'b0;
    rd_chk("minstreth_wrap", CSR_MINSTRETH, 32'h0);
    rd_chk("minstret_wrap", CSR_MINSTRET, 32'h0);

    // Timer interrupt entry and MRET
    wr(2'b01, CSR_MTVEC, 32'h0000_0101);
    rd_chk("mtvec_align", CSR_MTVEC, 32'h0000_0100);
    wr(2'b01, CSR_MIE, 32'h0000_0080);
    rd_chk("mie_mtie", CSR_MIE, 32'h0000_0080);
    op_chk("set_mie", 2'b10, CSR_MSTATUS, 32'h8, 32'h0000_1800);
    rd_chk("mstatus_mie", CSR_MSTATUS, 32'h0000_1808);
    timer_irq = 1'b1; PC_EXE = 32'h40;
    expect_out("timer_trap", 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
    tick();
    rd_chk("mip_timer", CSR_MIP, 32'h0000_0080);
    timer_irq = 1'b0;
    rd_chk("timer_mepc", CSR_MEPC, 32'h40);
    rd_chk("timer_mcause", CSR_MCAUSE, CAUSE_TIMER_IRQ);
    rd_chk("trap_mstatus", CSR_MSTATUS, 32'h0000_1880);
    mret_EXE = 1'b1;
    expect_out("mret", 1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    tick();
    rd_chk("mret_mstatus", CSR_MSTATUS, 32'h0000_1888);

    // Simultaneous interrupts with a CSR write in the trap cycle
    op_chk("set_meie", 2'b10, CSR_MIE, 32'h0000_0800, 32'h0000_0080);
    ext_irq = 1'b1; timer_irq = 1'b1; PC_EXE = 32'h60;
    csr_cmd(2'b01, CSR_MSCRATCH, 32'h5555_5555, 1'b0);
    expect_out("dual_trap", 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'hDEAD_BE00);
    tick();
    ext_irq = 1'b0; timer_irq = 1'b0;
    rd_chk("dual_mcause", CSR_MCAUSE, CAUSE_EXT_IRQ);
    rd_chk("trap_write_dropped", CSR_MSCRATCH, 32'hDEAD_BE00);
    rd_chk("dual_mepc", CSR_MEPC, 32'h60);
    rd_chk("dual_mstatus", CSR_MSTATUS, 32'h0000_1880);

    // WFI with MIE=0: wake without trap
    PC_EXE = 32'h80; wfi_EXE = 1'b1;
    expect_out("wfi_issue", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    expect_out("sleep_entered", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    tick();
    csr_cmd(2'b01, CSR_MSCRATCH, 32'h7777_7777, 1'b0);
    expect_out("sleep_write", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'hDEAD_BE00);
    tick();
    mret_EXE = 1'b1;
    expect_out("sleep_mret", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    tick();
    ext_irq = 1'b1;
    expect_out("wake_no_trap", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    tick();
    ext_irq = 1'b0;
    expect_out("resumed", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    rd_chk("sleep_write_dropped", CSR_MSCRATCH, 32'hDEAD_BE00);
    rd_chk("sleep_mret_dropped", CSR_MSTATUS, 32'h0000_1880);

    // WFI with MIE=1: wake with trap, mepc = WFI PC + 4
    op_chk("set_mie2", 2'b10, CSR_MSTATUS, 32'h8, 32'h0000_1880);
    PC_EXE = 32'h80; wfi_EXE = 1'b1;
    expect_out("wfi_issue2", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    expect_out("sleep_entered2", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    tick();
    ext_irq = 1'b1; PC_EXE = 32'h88;
    expect_out("wake_trap", 1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0);
    tick();
    ext_irq = 1'b0;
    expect_out("resumed2", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    rd_chk("wake_mepc", CSR_MEPC, 32'h84);
    rd_chk("wake_mcause", CSR_MCAUSE, CAUSE_EXT_IRQ);
    rd_chk("wake_mstatus", CSR_MSTATUS, 32'h0000_1880);

    // WFI with an interrupt already pending is a NOP
    ext_irq = 1'b1; PC_EXE = 32'h90; wfi_EXE = 1'b1;
    expect_out("wfi_nop", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    expect_out("wfi_nop_run", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    ext_irq = 1'b0;

    // Reset while sleeping
    PC_EXE = 32'hA0; wfi_EXE = 1'b1;
    tick();
    expect_out("sleep_before_rst", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_chk("rst_mcycle", CSR_MCYCLE, 32'h0);
    rd_chk("rst_minstret", CSR_MINSTRET, 32'h0);
    rd_chk("rst_mcycleh", CSR_MCYCLEH, 32'h0);
    rd_chk("rst_mstatus2", CSR_MSTATUS, 32'h0000_1800);
    rd_chk("rst_mscratch", CSR_MSCRATCH, 32'h0);
    rd_chk("mcycle_after_rst", CSR_MCYCLE, 32'h5);

    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL leftover: %0d expected entries never observed, required 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
